// File: rtl/miriscv_data_arbiter_if.sv
// Bus bundle between the two requesters, the data arbiter and the data memory.
// Handshake: a requester raises mN_req_i with a stable payload and holds it until
// mN_gnt_o is seen high in the same cycle; the payload may change the cycle after.
// The memory accepts data_req_o in any cycle (no backpressure) and answers every
// read with exactly one data_rvalid_i pulse, in issue order; writes get no answer.
interface miriscv_data_arbiter_if #(
  parameter int XLEN = 32
);

  // requester 0 (core LSU)
  logic              m0_req_i;
  logic              m0_we_i;
  logic [XLEN/8-1:0] m0_be_i;
  logic [XLEN-1:0]   m0_addr_i;
  logic [XLEN-1:0]   m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [XLEN-1:0]   m0_rdata_o;

  // requester 1 (debug / DMA master)
  logic              m1_req_i;
  logic              m1_we_i;
  logic [XLEN/8-1:0] m1_be_i;
  logic [XLEN-1:0]   m1_addr_i;
  logic [XLEN-1:0]   m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [XLEN-1:0]   m1_rdata_o;

  // shared data memory port
  logic              data_req_o;
  logic              data_we_o;
  logic [XLEN/8-1:0] data_be_o;
  logic [XLEN-1:0]   data_addr_o;
  logic [XLEN-1:0]   data_wdata_o;
  logic              data_rvalid_i;
  logic [XLEN-1:0]   data_rdata_i;

  // arbiter view
  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_rvalid_i, data_rdata_i
  );

  // environment view (requesters plus memory)
  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_rvalid_i, data_rdata_i
  );

endinterface

// File: rtl/miriscv_data_arbiter.sv
// miriscv_data_arbiter: shares one data-memory port between the core LSU (port 0)
// and a debug/DMA master (port 1). One request is granted and forwarded per cycle
// with zero added latency; an ID FIFO remembers which port issued each outstanding
// read so the in-order read responses are steered back to the right requester.
//
// Build option: define MIRISCV_DATA_ARB_RR_EN for round-robin arbitration between
// the two ports; by default port 0 has fixed priority and no pointer flop exists.
//
// dbg_count_o exposes the outstanding-read count so checkers can observe it.
module miriscv_data_arbiter #(
  parameter  int XLEN            = 32,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  miriscv_data_arbiter_if.slave     bus,
  output logic                      arb_err_o,
  output logic [CNT_W-1:0]          dbg_count_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // outstanding-read ID FIFO: one bit per entry, 1 = port 1 issued the read
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic fifo_full;
  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic push;
  logic pop;
  logic head_id;

  // Wrap-around increment for FIFO pointers of arbitrary depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // A full FIFO only holds back reads; the same-cycle pop is deliberately ignored
  // so grant never depends on data_rvalid_i, keeping the grant path short.
  assign fifo_full = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign elig0     = bus.m0_req_i & (bus.m0_we_i | ~fifo_full);
  assign elig1     = bus.m1_req_i & (bus.m1_we_i | ~fifo_full);

`ifdef MIRISCV_DATA_ARB_RR_EN
  // rr_ptr_q names the port preferred when both ports are eligible.
  logic rr_ptr_q;

  // Preferred port wins a tie; a lone eligible port always wins.
  always_comb begin
    gnt0 = elig0 & (~elig1 | ~rr_ptr_q);
    gnt1 = elig1 & (~elig0 |  rr_ptr_q);
  end

  // After any grant, prefer the other port next time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= 1'b0;
    end else if (gnt0) begin
      rr_ptr_q <= 1'b1;
    end else if (gnt1) begin
      rr_ptr_q <= 1'b0;
    end
  end
`else
  // Fixed priority: the core port always wins when it is eligible.
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1 & ~elig0;
  end
`endif

  assign bus.m0_gnt_o = gnt0;
  assign bus.m1_gnt_o = gnt1;

  // Forward the winner's payload; an idle cycle drives an all-zero request.
  always_comb begin
    bus.data_req_o   = 1'b0;
    bus.data_we_o    = 1'b0;
    bus.data_be_o    = '0;
    bus.data_addr_o  = '0;
    bus.data_wdata_o = '0;
    if (gnt0) begin
      bus.data_req_o   = 1'b1;
      bus.data_we_o    = bus.m0_we_i;
      bus.data_be_o    = bus.m0_be_i;
      bus.data_addr_o  = bus.m0_addr_i;
      bus.data_wdata_o = bus.m0_wdata_i;
    end else if (gnt1) begin
      bus.data_req_o   = 1'b1;
      bus.data_we_o    = bus.m1_we_i;
      bus.data_be_o    = bus.m1_be_i;
      bus.data_addr_o  = bus.m1_addr_i;
      bus.data_wdata_o = bus.m1_wdata_i;
    end
  end

  // A granted read records its issuer; a response retires the oldest entry.
  // A response arriving with nothing outstanding is spurious and is not popped.
  assign push    = (gnt0 & ~bus.m0_we_i) | (gnt1 & ~bus.m1_we_i);
  assign pop     = bus.data_rvalid_i & (count_q != '0);
  assign head_id = id_q[rd_ptr_q];

  assign bus.m0_rvalid_o = pop & ~head_id;
  assign bus.m1_rvalid_o = pop &  head_id;
  assign bus.m0_rdata_o  = bus.data_rdata_i;
  assign bus.m1_rdata_o  = bus.data_rdata_i;

  // ID FIFO storage, pointers and occupancy; push+pop together keeps the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= gnt1;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Sticky error: a response with no read outstanding, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arb_err_o <= 1'b0;
    end else if (bus.data_rvalid_i && (count_q == '0)) begin
      arb_err_o <= 1'b1;
    end
  end

  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for miriscv_data_arbiter: directed scenarios plus two-port read traffic,
// checked against a cycle model of the arbiter and an expected-response queue.
module tb_miriscv_data_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 2;
  localparam int W    = XLEN + 1;  // {port id, read data}

  logic       clk_i;
  logic       rst_i;
  logic       arb_err_o;
  logic [1:0] dbg_count;

  miriscv_data_arbiter_if #(.XLEN(XLEN)) bus ();

  miriscv_data_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .arb_err_o   (arb_err_o),
    .dbg_count_o (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  logic [W-1:0] exp_q[$];
  mem_rsp_t     mem_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mem_lat  = 3;
  bit mem_auto = 0;
  int mcount   = 0;
  bit mptr     = 0;
  bit merr     = 0;
  bit mg0      = 0;
  bit mg1      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory contents seen by the bench; 0x100 holds the test word.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'hA5A5_0000) + 32'h1;
  endfunction

  task automatic model_reset();
    mcount = 0;
    mptr   = 0;
    merr   = 0;
    exp_q.delete();
    mem_q.delete();
  endtask

  // Reference arbiter: predicts this cycle's outputs from the bench's own inputs,
  // compares, then advances its state as the clock edge will.
  task automatic check_model();
    bit full, e0, e1, g0, g1, push, pop;
    logic [W-1:0] e;
    full = (mcount == MAXO);
    e0 = bus.m0_req_i & (bus.m0_we_i | !full);
    e1 = bus.m1_req_i & (bus.m1_we_i | !full);
`ifdef MIRISCV_DATA_ARB_RR_EN
    if (e0 && e1) begin g0 = !mptr; g1 = mptr; end
    else begin g0 = e0; g1 = e1; end
`else
    g0 = e0;
    g1 = e1 & !e0;
`endif
    check("gnt0", bus.m0_gnt_o, g0);
    check("gnt1", bus.m1_gnt_o, g1);
    check("data_req", bus.data_req_o, g0 | g1);
    if (g0) begin
      check("data_we", bus.data_we_o, bus.m0_we_i);
      check("data_be", bus.data_be_o, bus.m0_be_i);
      check("data_addr", bus.data_addr_o, bus.m0_addr_i);
      check("data_wdata", bus.data_wdata_o, bus.m0_wdata_i);
    end else if (g1) begin
      check("data_we", bus.data_we_o, bus.m1_we_i);
      check("data_be", bus.data_be_o, bus.m1_be_i);
      check("data_addr", bus.data_addr_o, bus.m1_addr_i);
      check("data_wdata", bus.data_wdata_o, bus.m1_wdata_i);
    end else begin
      check("idle_we", bus.data_we_o, 0);
      check("idle_be", bus.data_be_o, 0);
      check("idle_addr", bus.data_addr_o, 0);
      check("idle_wdata", bus.data_wdata_o, 0);
    end
    check("count", dbg_count, mcount);
    check("arb_err", arb_err_o, merr);

    pop = bus.data_rvalid_i && (mcount != 0);
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid0", bus.m0_rvalid_o, !e[XLEN]);
        check("rvalid1", bus.m1_rvalid_o, e[XLEN]);
        check("rdata", bus.m0_rdata_o, e[XLEN-1:0]);
        check("rdata1", bus.m1_rdata_o, e[XLEN-1:0]);
      end
    end else begin
      check("no_rvalid0", bus.m0_rvalid_o, 0);
      check("no_rvalid1", bus.m1_rvalid_o, 0);
      if (bus.data_rvalid_i) merr = 1;
    end

    push = (g0 && !bus.m0_we_i) || (g1 && !bus.m1_we_i);
    if (push) exp_q.push_back({g1, memf(g1 ? bus.m1_addr_i : bus.m0_addr_i)});
    mcount = mcount + int'(push) - int'(pop);
    if (g0) mptr = 1;
    else if (g1) mptr = 0;
    mg0 = g0;
    mg1 = g1;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: inputs are already applied (just after the edge); the
  // memory model answers due reads, outputs are checked mid-cycle.
  task automatic cycle();
    if (mem_auto) begin
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = mem_q[0].data;
        mem_q.delete(0);
      end else begin
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = $urandom;
      end
    end
    #2;
    check_model();
    if (mem_auto && bus.data_req_o && !bus.data_we_o)
      mem_q.push_back('{cyc + mem_lat, memf(bus.data_addr_o)});
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle_reqs();
    bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_be_i = 0; bus.m0_addr_i = 0; bus.m0_wdata_i = 0;
    bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_be_i = 0; bus.m1_addr_i = 0; bus.m1_wdata_i = 0;
  endtask

  task automatic drive_m0(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bus.m0_req_i = 1; bus.m0_we_i = we; bus.m0_be_i = 4'hF;
    bus.m0_addr_i = addr; bus.m0_wdata_i = wd;
  endtask

  task automatic drive_m1(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be);
    bus.m1_req_i = 1; bus.m1_we_i = we; bus.m1_be_i = be;
    bus.m1_addr_i = addr; bus.m1_wdata_i = wd;
  endtask

  // Stop requesting and let all outstanding reads return (bounded).
  task automatic drain();
    idle_reqs();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a0, a1, w0, w1;
    rst_i = 1;
    idle_reqs();
    bus.data_rvalid_i = 0;
    bus.data_rdata_i  = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    model_reset();

    // 1: idle after reset
    #1;
    check("t1_gnt0", bus.m0_gnt_o, 0);
    check("t1_gnt1", bus.m1_gnt_o, 0);
    check("t1_rvalid0", bus.m0_rvalid_o, 0);
    check("t1_rvalid1", bus.m1_rvalid_o, 0);
    check("t1_data_req", bus.data_req_o, 0);
    check("t1_arb_err", arb_err_o, 0);
    cycle();
    cycle();

    // 2: single m0 read of 0x100, response two cycles later
    mem_auto = 0;
    drive_m0(0, 32'h100, 32'h0);
    #1;
    check("t2_gnt0", bus.m0_gnt_o, 1);
    check("t2_addr", bus.data_addr_o, 32'h100);
    cycle();
    idle_reqs();
    cycle();
    bus.data_rvalid_i = 1;
    bus.data_rdata_i  = 32'hDEADBEEF;
    #1;
    check("t2_rvalid0", bus.m0_rvalid_o, 1);
    check("t2_rvalid1", bus.m1_rvalid_o, 0);
    check("t2_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
    cycle();
    bus.data_rvalid_i = 0;
    cycle();

    // 3: both ports read every cycle, latency 3 then latency 1
    mem_auto = 1;
    for (int pass = 0; pass < 2; pass++) begin
      mem_lat = (pass == 0) ? 3 : 1;
      a0 = 32'h1000;
      a1 = 32'h2000;
      w0 = $urandom_range(0, 32'hFFFF);
      w1 = $urandom_range(0, 32'hFFFF);
      for (int k = 0; k < 16; k++) begin
        drive_m0(0, a0, w0);
        drive_m1(0, a1, w1, 4'hF);
        cycle();
        if (mg0) begin a0 += 4; w0 = $urandom_range(0, 32'hFFFF); end
        if (mg1) begin a1 += 4; w1 = $urandom_range(0, 32'hFFFF); end
      end
      drain();
    end

    // 4: FIFO full, m0 read waits while an m1 write goes through
    mem_lat = 6;
    drive_m0(0, 32'h300, 0);
    cycle();
    drive_m0(0, 32'h304, 0);
    cycle();
    drive_m0(0, 32'h308, 0);
    drive_m1(1, 32'h200, 32'h1234_5678, 4'b0011);
    #1;
    check("t4_count_full", dbg_count, 2);
    check("t4_gnt0", bus.m0_gnt_o, 0);
    check("t4_gnt1", bus.m1_gnt_o, 1);
    check("t4_we", bus.data_we_o, 1);
    check("t4_be", bus.data_be_o, 4'b0011);
    check("t4_addr", bus.data_addr_o, 32'h200);
    cycle();
    check("t4_count_kept", dbg_count, 2);
    bus.m1_req_i = 0;
    for (int i = 0; i < 20 && bus.m0_req_i; i++) begin
      cycle();
      if (mg0) bus.m0_req_i = 0;
    end
    check("t4_m0_granted", bus.m0_req_i, 0);
    drain();

    // 5: response with nothing outstanding
    mem_auto = 0;
    bus.data_rvalid_i = 1;
    bus.data_rdata_i  = 32'h55;
    #1;
    check("t5_rvalid0", bus.m0_rvalid_o, 0);
    check("t5_rvalid1", bus.m1_rvalid_o, 0);
    check("t5_err_before", arb_err_o, 0);
    cycle();
    bus.data_rvalid_i = 0;
    check("t5_err_set", arb_err_o, 1);
    repeat (3) cycle();
    check("t5_err_sticky", arb_err_o, 1);

    // 6: asynchronous reset with two reads outstanding, then a stale response
    mem_auto = 1;
    mem_lat  = 6;
    drive_m0(0, 32'h400, 0);
    cycle();
    drive_m0(0, 32'h404, 0);
    cycle();
    idle_reqs();
    check("t6_count_pre", dbg_count, 2);
    #2;
    rst_i = 1;
    #1;
    check("t6_count_rst", dbg_count, 0);
    check("t6_err_rst", arb_err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 0;
    model_reset();
    mem_auto = 0;
    bus.data_rvalid_i = 1;
    bus.data_rdata_i  = memf(32'h400);
    #1;
    check("t6_stale_rvalid0", bus.m0_rvalid_o, 0);
    cycle();
    bus.data_rvalid_i = 0;
    check("t6_err_stale", arb_err_o, 1);
    cycle();

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
